raster_atomic_unit: RTL and testbench
=====================================

Name: raster_atomic_unit

Overview:
Hardware read-modify-write engine that replaces the software TID==k serialization loop used for framebuffer rasterization.
- Accepts one warp-wide batch of per-lane pixel coordinates plus an active mask.
- Clips each lane against the framebuffer, merges lanes that hit the same 32-bit word, and performs one atomic RMW per distinct word.
- Sits between the LSU issue path and the memory port, in parallel with normal LDR/STR traffic.
- Generalises the fixed 64x64 1bpp OR-only scheme to a parametric width, height, base and lane count, with three raster ops and write elision.

Parameters:
NUM_LANES, 32, lanes per request (power of 2, ≤32)
FB_WIDTH, 64, pixels per row (multiple of 32)
FB_HEIGHT, 64, rows
FB_BASE, 32'h2000, byte address of pixel (0,0)
COORD_W, 16, unsigned coordinate width
ADDR_W, 32, memory address width

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
req_valid  in  1  batch valid
req_ready  out  1  unit idle, can accept a batch
req_mask  in  NUM_LANES  active lanes
req_x  in  NUM_LANES*COORD_W  packed x coordinates (lane 0 in LSBs)
req_y  in  NUM_LANES*COORD_W  packed y coordinates
req_op  in  2  raster_op_e: OR set, ANDN clear, XOR toggle
mem_req_valid  out  1  memory request valid
mem_req_ready  in  1  memory accepts request
mem_req_we  out  1  1 = write, 0 = read
mem_req_addr  out  ADDR_W  word-aligned byte address
mem_req_wdata  out  32  write data
mem_rsp_valid  in  1  read data valid
mem_rsp_rdata  in  32  read data
done  out  1  one-cycle pulse when the batch completes
words_written  out  6  writes issued for the last batch
lanes_clipped  out  6  lanes dropped by clipping in the last batch
busy  out  1  state != IDLE

Behaviour:
- Reset values: all outputs 0 except req_ready=1.
- Reset asserted mid-operation: the FSM returns to IDLE on the next edge, the pending lane set is discarded, mem_req_valid=0. No partial write is issued after reset is sampled.
- Accept: req_valid && req_ready latches mask, coordinates and op.
  - Lane clipped when x≥FB_WIDTH or y≥FB_HEIGHT. Clipped lanes are cleared from the pending mask and counted into lanes_clipped.
- Addressing per lane: addr = FB_BASE + y*(FB_WIDTH/8) + (x>>5)*4; bit = x[4:0]. Arithmetic is done at ADDR_W width.
- FSM states:
  - IDLE: on accept, go to SCAN, or to DONE if no lanes remain after clipping.
  - SCAN (1 cycle): the leader is the lowest pending lane. Every pending lane with an identical addr joins the group. Group mask is the OR of 1<<bit for OR/ANDN, and the XOR-reduce for XOR, so duplicate toggles cancel. Group lanes are cleared from pending. Go to RD_REQ.
  - RD_REQ: mem_req_valid=1, we=0, addr=group addr, held until mem_req_ready. Then go to RD_WAIT.
  - RD_WAIT: on mem_rsp_valid compute new = old|m, old&~m, or old^m.
    - new==old (including XOR with m=0): skip the write; go to SCAN if lanes are pending, else DONE.
    - Otherwise go to WR_REQ.
  - WR_REQ: we=1, wdata=new, held until ready. On handshake increment words_written. Then SCAN if lanes are pending, else DONE.
  - DONE: done=1 for one cycle, go to IDLE. Counters hold until the next accept, which clears them.
- Exactly one memory request is outstanding at any time. RMW atomicity is guaranteed only against this unit itself.
- mem_req_* is stable while valid && !ready.
- Latency per word, with zero-wait memory and 1-cycle read response: SCAN, RD_REQ, RD_WAIT, WR_REQ = 4 cycles. A full batch takes 4*groups + 2 cycles from accept to done.
- req_op=2'b11 is treated as OR.

Decomposition:
- Package additions to simt_pkg: raster_op_e {ROP_OR, ROP_ANDN, ROP_XOR}, rau_state_e {RAU_IDLE, RAU_SCAN, RAU_RD_REQ, RAU_RD_WAIT, RAU_WR_REQ, RAU_DONE}.
- Sub-module raster_lane_merge (combinational): inputs are pending mask, per-lane addr/bit and op. Outputs are leader valid, group addr, group lane mask and merged bit mask.

Test Plan:
- Basic set: lanes 0/1 at (5,3),(6,3), op OR, memory 0 → one read and one write at 0x2018, wdata 0x00000060, words_written=1, done 6 cycles after accept.
- Multi-word merge: lanes 0,1,2 at (5,3),(40,3),(7,3) → 0x2018 written first with 0xA0, then 0x201C with 0x100, words_written=2. Lane 2 is merged with lane 0.
- Clip: lane 0 at (64,0), lane 1 at (0,64), lane 2 at (0,0) → lanes_clipped=2, single write 0x2000=0x1. An all-clipped batch → done with no memory traffic.
- XOR cancel and elision: 32 lanes all at (3,0), op XOR → one read, no write, words_written=0. OR onto memory already 0x8 at 0x2000 → no write.
- ANDN with backpressure: memory 0xFFFFFFFF at 0x2000, lane at (31,0), mem_req_ready low for 3 cycles → request fields stable while stalled, write 0x7FFFFFFF.
- Reset mid-RD_WAIT: assert rst_n=0 for one cycle → busy=0, req_ready=1, no write issued, and a following batch completes normally.

Source files
------------

// File: rtl/raster_atomic_unit_pkg.sv
// Shared types and helpers for the raster read-modify-write engine.
package raster_atomic_unit_pkg;

    typedef enum logic [1:0] {
        ROP_OR   = 2'd0,
        ROP_ANDN = 2'd1,
        ROP_XOR  = 2'd2
    } raster_op_e;

    typedef enum logic [2:0] {
        RAU_IDLE,
        RAU_SCAN,
        RAU_RD_REQ,
        RAU_RD_WAIT,
        RAU_WR_REQ,
        RAU_DONE
    } rau_state_e;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned CNT_W  = 6;

    // The unused encoding 2'b11 behaves as a plain set.
    function automatic raster_op_e decode_op(input logic [1:0] op);
        case (op)
            2'b01:   return ROP_ANDN;
            2'b10:   return ROP_XOR;
            default: return ROP_OR;
        endcase
    endfunction

    function automatic logic [WORD_W-1:0] apply_op(input raster_op_e op,
                                                   input logic [WORD_W-1:0] old_w,
                                                   input logic [WORD_W-1:0] m);
        case (op)
            ROP_ANDN: return old_w & ~m;
            ROP_XOR:  return old_w ^ m;
            default:  return old_w | m;
        endcase
    endfunction

endpackage

// File: rtl/raster_atomic_unit_if.sv
// Request, memory and status bundle of the raster atomic unit.
interface raster_atomic_unit_if #(
    parameter int unsigned NUM_LANES = 32,
    parameter int unsigned COORD_W   = 16,
    parameter int unsigned ADDR_W    = 32
) ();
    logic                         req_valid;
    logic                         req_ready;
    logic [NUM_LANES-1:0]         req_mask;
    logic [NUM_LANES*COORD_W-1:0] req_x;
    logic [NUM_LANES*COORD_W-1:0] req_y;
    logic [1:0]                   req_op;

    logic                         mem_req_valid;
    logic                         mem_req_ready;
    logic                         mem_req_we;
    logic [ADDR_W-1:0]            mem_req_addr;
    logic [31:0]                  mem_req_wdata;
    logic                         mem_rsp_valid;
    logic [31:0]                  mem_rsp_rdata;

    logic                         done;
    logic [5:0]                   words_written;
    logic [5:0]                   lanes_clipped;
    logic                         busy;

    // Unit side: accepts batches, drives the memory port and status.
    modport slave (
        input  req_valid, req_mask, req_x, req_y, req_op,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
        output req_ready,
        output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
        output done, words_written, lanes_clipped, busy
    );

    // Client side: issues batches and serves the memory port.
    modport master (
        output req_valid, req_mask, req_x, req_y, req_op,
        output mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
        input  req_ready,
        input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
        input  done, words_written, lanes_clipped, busy
    );
endinterface

// File: rtl/raster_atomic_unit_lane_merge.sv
// Picks the lowest pending lane as leader and gathers every pending lane
// that targets the same word into one group with a merged bit mask.
module raster_lane_merge
    import raster_atomic_unit_pkg::*;
#(
    parameter int unsigned NUM_LANES = 32,
    parameter int unsigned ADDR_W    = 32
) (
    input  logic [NUM_LANES-1:0] i_pending,
    input  logic [ADDR_W-1:0]    i_addr [NUM_LANES],
    input  logic [4:0]           i_bit  [NUM_LANES],
    input  raster_op_e           i_op,
    output logic                 o_leader_valid,
    output logic [ADDR_W-1:0]    o_group_addr,
    output logic [NUM_LANES-1:0] o_group_lanes,
    output logic [WORD_W-1:0]    o_bit_mask
);

    // Leader search runs from the top lane down so the lowest pending lane wins.
    always_comb begin
        o_leader_valid = 1'b0;
        o_group_addr   = '0;
        for (int unsigned i = NUM_LANES; i > 0; i--) begin
            if (i_pending[i-1]) begin
                o_leader_valid = 1'b1;
                o_group_addr   = i_addr[i-1];
            end
        end
    end

    // Group membership and bit merge; XOR folds so repeated toggles cancel.
    always_comb begin
        o_group_lanes = '0;
        o_bit_mask    = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            if (i_pending[i] && (i_addr[i] == o_group_addr)) begin
                o_group_lanes[i] = 1'b1;
                if (i_op == ROP_XOR) begin
                    o_bit_mask = o_bit_mask ^ (WORD_W'(1) << i_bit[i]);
                end else begin
                    o_bit_mask = o_bit_mask | (WORD_W'(1) << i_bit[i]);
                end
            end
        end
    end

endmodule

// File: rtl/raster_atomic_unit.sv
// Batched framebuffer read-modify-write engine: clips lanes, merges lanes
// sharing a word, and performs one atomic RMW per distinct word.
module raster_atomic_unit
    import raster_atomic_unit_pkg::*;
#(
    parameter int unsigned NUM_LANES = 32,
    parameter int unsigned FB_WIDTH  = 64,
    parameter int unsigned FB_HEIGHT = 64,
    parameter logic [31:0] FB_BASE   = 32'h2000,
    parameter int unsigned COORD_W   = 16,
    parameter int unsigned ADDR_W    = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    raster_atomic_unit_if.slave  bus
);

    rau_state_e              r_state;
    rau_state_e              w_state_nxt;

    logic [NUM_LANES-1:0]    r_pending;
    logic [COORD_W-1:0]      r_x [NUM_LANES];
    logic [COORD_W-1:0]      r_y [NUM_LANES];
    raster_op_e              r_op;
    logic [ADDR_W-1:0]       r_gaddr;
    logic [WORD_W-1:0]       r_gmask;
    logic [WORD_W-1:0]       r_wdata;
    logic [CNT_W-1:0]        r_words;
    logic [CNT_W-1:0]        r_clipped;

    logic [NUM_LANES-1:0]    w_clip;
    logic [NUM_LANES-1:0]    w_accept_pending;
    logic [CNT_W-1:0]        w_clip_cnt;
    logic [ADDR_W-1:0]       w_lane_addr [NUM_LANES];
    logic [4:0]              w_lane_bit  [NUM_LANES];
    logic                    w_leader_valid;
    logic [ADDR_W-1:0]       w_group_addr;
    logic [NUM_LANES-1:0]    w_group_lanes;
    logic [WORD_W-1:0]       w_bit_mask;
    logic [WORD_W-1:0]       w_new;
    logic                    w_elide;

    logic                    w_req_ready;
    logic                    w_mem_req_valid;
    logic                    w_mem_we;
    logic                    w_done;
    logic                    w_busy;

    // Clip test on the incoming batch and count of active lanes dropped.
    always_comb begin
        w_clip     = '0;
        w_clip_cnt = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            w_clip[i] = (32'(bus.req_x[i*COORD_W +: COORD_W]) >= 32'(FB_WIDTH)) ||
                        (32'(bus.req_y[i*COORD_W +: COORD_W]) >= 32'(FB_HEIGHT));
            if (bus.req_mask[i] && w_clip[i]) begin
                w_clip_cnt = w_clip_cnt + CNT_W'(1);
            end
        end
        w_accept_pending = bus.req_mask & ~w_clip;
    end

    // Per-lane word address and bit index from the latched coordinates.
    always_comb begin
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            w_lane_addr[i] = ADDR_W'(FB_BASE)
                           + ADDR_W'(r_y[i]) * ADDR_W'(FB_WIDTH / 8)
                           + (ADDR_W'(r_x[i] >> 5) << 2);
            w_lane_bit[i]  = r_x[i][4:0];
        end
    end

    raster_lane_merge #(
        .NUM_LANES (NUM_LANES),
        .ADDR_W    (ADDR_W)
    ) u_merge (
        .i_pending      (r_pending),
        .i_addr         (w_lane_addr),
        .i_bit          (w_lane_bit),
        .i_op           (r_op),
        .o_leader_valid (w_leader_valid),
        .o_group_addr   (w_group_addr),
        .o_group_lanes  (w_group_lanes),
        .o_bit_mask     (w_bit_mask)
    );

    assign w_new   = apply_op(r_op, bus.mem_rsp_rdata, r_gmask);
    assign w_elide = (w_new == bus.mem_rsp_rdata);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= RAU_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and output decode.
    always_comb begin
        w_state_nxt     = r_state;
        w_req_ready     = 1'b0;
        w_mem_req_valid = 1'b0;
        w_mem_we        = 1'b0;
        w_done          = 1'b0;
        w_busy          = (r_state != RAU_IDLE);
        case (r_state)
            RAU_IDLE: begin
                w_req_ready = 1'b1;
                if (bus.req_valid) begin
                    w_state_nxt = (|w_accept_pending) ? RAU_SCAN : RAU_DONE;
                end
            end
            RAU_SCAN: begin
                w_state_nxt = w_leader_valid ? RAU_RD_REQ : RAU_DONE;
            end
            RAU_RD_REQ: begin
                w_mem_req_valid = 1'b1;
                if (bus.mem_req_ready) begin
                    w_state_nxt = RAU_RD_WAIT;
                end
            end
            RAU_RD_WAIT: begin
                if (bus.mem_rsp_valid) begin
                    if (w_elide) begin
                        w_state_nxt = (|r_pending) ? RAU_SCAN : RAU_DONE;
                    end else begin
                        w_state_nxt = RAU_WR_REQ;
                    end
                end
            end
            RAU_WR_REQ: begin
                w_mem_req_valid = 1'b1;
                w_mem_we        = 1'b1;
                if (bus.mem_req_ready) begin
                    w_state_nxt = (|r_pending) ? RAU_SCAN : RAU_DONE;
                end
            end
            RAU_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = RAU_IDLE;
            end
            default: begin
                w_state_nxt = RAU_IDLE;
            end
        endcase
    end

    // Batch capture, group extraction, RMW data and per-batch counters.
    // Request address/data live in registers that only change in SCAN and
    // RD_WAIT, so they stay stable while a request is stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pending <= '0;
            r_op      <= ROP_OR;
            r_gaddr   <= '0;
            r_gmask   <= '0;
            r_wdata   <= '0;
            r_words   <= '0;
            r_clipped <= '0;
            for (int unsigned i = 0; i < NUM_LANES; i++) begin
                r_x[i] <= '0;
                r_y[i] <= '0;
            end
        end else begin
            case (r_state)
                RAU_IDLE: begin
                    if (bus.req_valid) begin
                        r_pending <= w_accept_pending;
                        r_op      <= decode_op(bus.req_op);
                        r_words   <= '0;
                        r_clipped <= w_clip_cnt;
                        for (int unsigned i = 0; i < NUM_LANES; i++) begin
                            r_x[i] <= bus.req_x[i*COORD_W +: COORD_W];
                            r_y[i] <= bus.req_y[i*COORD_W +: COORD_W];
                        end
                    end
                end
                RAU_SCAN: begin
                    r_gaddr   <= w_group_addr;
                    r_gmask   <= w_bit_mask;
                    r_pending <= r_pending & ~w_group_lanes;
                end
                RAU_RD_WAIT: begin
                    if (bus.mem_rsp_valid) begin
                        r_wdata <= w_new;
                    end
                end
                RAU_WR_REQ: begin
                    if (bus.mem_req_ready) begin
                        r_words <= r_words + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.req_ready     = w_req_ready;
    assign bus.mem_req_valid = w_mem_req_valid;
    assign bus.mem_req_we    = w_mem_we;
    assign bus.mem_req_addr  = r_gaddr;
    assign bus.mem_req_wdata = r_wdata;
    assign bus.done          = w_done;
    assign bus.busy          = w_busy;
    assign bus.words_written = r_words;
    assign bus.lanes_clipped = r_clipped;

endmodule

// File: tb/tb_raster_atomic_unit.sv
// Directed self-checking bench for raster_atomic_unit with a behavioural
// single-outstanding memory that answers reads one cycle after acceptance.
module tb_raster_atomic_unit;

    logic clk;
    logic rst_n;

    raster_atomic_unit_if #(.NUM_LANES(32), .COORD_W(16), .ADDR_W(32)) bus ();

    raster_atomic_unit #(
        .NUM_LANES (32),
        .FB_WIDTH  (64),
        .FB_HEIGHT (64),
        .FB_BASE   (32'h2000),
        .COORD_W   (16),
        .ADDR_W    (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [logic [31:0]];
    logic [31:0] wr_addr_q [$];
    logic [31:0] wr_data_q [$];
    int          rd_count = 0;
    int          stall_left = 0;

    logic [511:0] vx;
    logic [511:0] vy;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "simulation did not finish");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Memory responder: decides ready and records accepted requests at negedge.
    initial begin : mem_model
        logic        rsp_pend;
        logic [31:0] rsp_data;
        logic        stalling;
        logic [31:0] snap_addr;
        logic [31:0] snap_data;
        logic        snap_we;
        rsp_pend = 1'b0;
        rsp_data = '0;
        stalling = 1'b0;
        snap_addr = '0;
        snap_data = '0;
        snap_we   = 1'b0;
        bus.mem_req_ready = 1'b1;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_rdata = '0;
        forever begin
            @(negedge clk);
            bus.mem_rsp_valid = rsp_pend;
            bus.mem_rsp_rdata = rsp_data;
            rsp_pend = 1'b0;
            if (stalling && bus.mem_req_valid) begin
                check("stall_addr", bus.mem_req_addr, snap_addr);
                check("stall_wdata", bus.mem_req_wdata, snap_data);
                check("stall_we", {31'd0, bus.mem_req_we}, {31'd0, snap_we});
            end
            if (bus.mem_req_valid && stall_left > 0) begin
                if (!stalling) begin
                    snap_addr = bus.mem_req_addr;
                    snap_data = bus.mem_req_wdata;
                    snap_we   = bus.mem_req_we;
                end
                stalling = 1'b1;
                bus.mem_req_ready = 1'b0;
                stall_left--;
            end else begin
                stalling = 1'b0;
                bus.mem_req_ready = 1'b1;
                if (bus.mem_req_valid) begin
                    if (bus.mem_req_we) begin
                        mem[bus.mem_req_addr] = bus.mem_req_wdata;
                        wr_addr_q.push_back(bus.mem_req_addr);
                        wr_data_q.push_back(bus.mem_req_wdata);
                    end else begin
                        rd_count++;
                        rsp_pend = 1'b1;
                        rsp_data = mem.exists(bus.mem_req_addr) ? mem[bus.mem_req_addr] : 32'h0;
                    end
                end
            end
        end
    end

    task automatic clear_mem();
        mem.delete();
        wr_addr_q.delete();
        wr_data_q.delete();
        rd_count = 0;
        vx = '0;
        vy = '0;
    endtask

    task automatic set_lane(input int lane, input logic [15:0] x, input logic [15:0] y);
        vx[lane*16 +: 16] = x;
        vy[lane*16 +: 16] = y;
    endtask

    // Drives one batch and waits for done; cyc = accept cycle through done cycle inclusive.
    task automatic run_batch(input string tag, input logic [31:0] mask, input logic [1:0] op,
                             output int cyc);
        int k;
        @(negedge clk);
        check({tag, "_ready"}, {31'd0, bus.req_ready}, 32'd1);
        bus.req_valid = 1'b1;
        bus.req_mask  = mask;
        bus.req_x     = vx;
        bus.req_y     = vy;
        bus.req_op    = op;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_mask  = '0;
        cyc = -1;
        k   = 0;
        while (k < 300 && cyc < 0) begin
            if (bus.done) begin
                cyc = k + 2;
            end else begin
                @(negedge clk);
                k++;
            end
        end
        check({tag, "_done_seen"}, {31'd0, (cyc >= 0)}, 32'd1);
    endtask

    initial begin : stim
        int cyc;
        rst_n = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_mask  = '0;
        bus.req_x     = '0;
        bus.req_y     = '0;
        bus.req_op    = 2'b00;
        clear_mem();
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_mem_valid", {31'd0, bus.mem_req_valid}, 32'd0);
        check("rst_mem_we", {31'd0, bus.mem_req_we}, 32'd0);
        check("rst_mem_addr", bus.mem_req_addr, 32'd0);
        check("rst_mem_wdata", bus.mem_req_wdata, 32'd0);
        check("rst_words", {26'd0, bus.words_written}, 32'd0);
        check("rst_clipped", {26'd0, bus.lanes_clipped}, 32'd0);
        rst_n = 1'b1;

        // Basic set: two lanes in one word
        clear_mem();
        set_lane(0, 16'd5, 16'd3);
        set_lane(1, 16'd6, 16'd3);
        run_batch("basic", 32'h3, 2'b00, cyc);
        check("basic_cycles", cyc, 32'd6);
        check("basic_rd", rd_count, 32'd1);
        check("basic_nwr", wr_addr_q.size(), 32'd1);
        check("basic_wr_addr", wr_addr_q[0], 32'h2018);
        check("basic_wr_data", wr_data_q[0], 32'h60);
        check("basic_words", {26'd0, bus.words_written}, 32'd1);
        check("basic_clipped", {26'd0, bus.lanes_clipped}, 32'd0);
        @(negedge clk);
        check("basic_done_pulse", {31'd0, bus.done}, 32'd0);
        check("basic_idle", {31'd0, bus.busy}, 32'd0);
        check("basic_words_hold", {26'd0, bus.words_written}, 32'd1);

        // Multi-word merge: lane 2 joins lane 0
        clear_mem();
        set_lane(0, 16'd5, 16'd3);
        set_lane(1, 16'd40, 16'd3);
        set_lane(2, 16'd7, 16'd3);
        run_batch("merge", 32'h7, 2'b00, cyc);
        check("merge_cycles", cyc, 32'd10);
        check("merge_nwr", wr_addr_q.size(), 32'd2);
        check("merge_wr0_addr", wr_addr_q[0], 32'h2018);
        check("merge_wr0_data", wr_data_q[0], 32'hA0);
        check("merge_wr1_addr", wr_addr_q[1], 32'h201C);
        check("merge_wr1_data", wr_data_q[1], 32'h100);
        check("merge_words", {26'd0, bus.words_written}, 32'd2);

        // Clipping on x, on y, plus one in-range lane
        clear_mem();
        set_lane(0, 16'd64, 16'd0);
        set_lane(1, 16'd0, 16'd64);
        set_lane(2, 16'd0, 16'd0);
        run_batch("clip", 32'h7, 2'b00, cyc);
        check("clip_cycles", cyc, 32'd6);
        check("clip_clipped", {26'd0, bus.lanes_clipped}, 32'd2);
        check("clip_nwr", wr_addr_q.size(), 32'd1);
        check("clip_wr_addr", wr_addr_q[0], 32'h2000);
        check("clip_wr_data", wr_data_q[0], 32'h1);

        // All lanes clipped: straight to done, no memory traffic
        clear_mem();
        set_lane(0, 16'd64, 16'd0);
        set_lane(1, 16'd0, 16'd64);
        run_batch("allclip", 32'h3, 2'b00, cyc);
        check("allclip_cycles", cyc, 32'd2);
        check("allclip_rd", rd_count, 32'd0);
        check("allclip_nwr", wr_addr_q.size(), 32'd0);
        check("allclip_clipped", {26'd0, bus.lanes_clipped}, 32'd2);
        check("allclip_words", {26'd0, bus.words_written}, 32'd0);

        // XOR from 32 lanes on the same pixel cancels; write elided
        clear_mem();
        for (int i = 0; i < 32; i++) set_lane(i, 16'd3, 16'd0);
        run_batch("xor", 32'hFFFF_FFFF, 2'b10, cyc);
        check("xor_cycles", cyc, 32'd5);
        check("xor_rd", rd_count, 32'd1);
        check("xor_nwr", wr_addr_q.size(), 32'd0);
        check("xor_words", {26'd0, bus.words_written}, 32'd0);

        // OR onto a bit that is already set: write elided
        clear_mem();
        mem[32'h2000] = 32'h8;
        set_lane(0, 16'd3, 16'd0);
        run_batch("elide", 32'h1, 2'b00, cyc);
        check("elide_cycles", cyc, 32'd5);
        check("elide_rd", rd_count, 32'd1);
        check("elide_nwr", wr_addr_q.size(), 32'd0);
        check("elide_mem", mem[32'h2000], 32'h8);

        // ANDN on bit 31 with 3 stall cycles on the read request
        clear_mem();
        mem[32'h2000] = 32'hFFFF_FFFF;
        set_lane(0, 16'd31, 16'd0);
        stall_left = 3;
        run_batch("andn", 32'h1, 2'b01, cyc);
        check("andn_cycles", cyc, 32'd9);
        check("andn_nwr", wr_addr_q.size(), 32'd1);
        check("andn_wr_addr", wr_addr_q[0], 32'h2000);
        check("andn_wr_data", wr_data_q[0], 32'h7FFF_FFFF);
        check("andn_words", {26'd0, bus.words_written}, 32'd1);

        // Op encoding 2'b11 sets like OR
        clear_mem();
        set_lane(0, 16'd1, 16'd0);
        run_batch("op3", 32'h1, 2'b11, cyc);
        check("op3_nwr", wr_addr_q.size(), 32'd1);
        check("op3_wr_data", wr_data_q[0], 32'h2);

        // Reset while waiting for read data
        clear_mem();
        set_lane(0, 16'd2, 16'd0);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_mask  = 32'h1;
        bus.req_x     = vx;
        bus.req_y     = vy;
        bus.req_op    = 2'b00;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_mask  = '0;
        @(negedge clk);
        check("rrst_rdreq_valid", {31'd0, bus.mem_req_valid}, 32'd1);
        check("rrst_rdreq_we", {31'd0, bus.mem_req_we}, 32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("rrst_busy", {31'd0, bus.busy}, 32'd0);
        check("rrst_ready", {31'd0, bus.req_ready}, 32'd1);
        check("rrst_mem_valid", {31'd0, bus.mem_req_valid}, 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("rrst_nwr", wr_addr_q.size(), 32'd0);
        check("rrst_idle_valid", {31'd0, bus.mem_req_valid}, 32'd0);
        run_batch("after_rst", 32'h1, 2'b00, cyc);
        check("after_rst_cycles", cyc, 32'd6);
        check("after_rst_nwr", wr_addr_q.size(), 32'd1);
        check("after_rst_wr_data", wr_data_q[0], 32'h4);
        check("after_rst_words", {26'd0, bus.words_written}, 32'd1);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
